// File: rtl/otp_pkg.sv
// rtl/otp_pkg.sv - shared constants, sizing helpers and state type for the OTP datapath
package otp_pkg;

  localparam int KEY_SIZE = 16;
  localparam int MSG_SIZE = 240;

  // Number of key-width chunks in a message; degenerate sizes collapse to 1
  function automatic int num_chunks(input int msg_w, input int key_w);
    if (key_w <= 0 || msg_w < key_w) return 1;
    return msg_w / key_w;
  endfunction

  // Width of a chunk index counter, never narrower than one bit
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } chunk_state_t;

endpackage

// File: rtl/otp_chunk_streamer.sv
// rtl/otp_chunk_streamer.sv - splits one message into key-width chunks over valid/ready
module otp_chunk_streamer
  import otp_pkg::*;
#(
  parameter  int MSG_W     = MSG_SIZE,
  parameter  int KEY_W     = KEY_SIZE,
  parameter  int MSB_FIRST = 1,
  localparam int N         = num_chunks(MSG_W, KEY_W),
  localparam int IDX_W     = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MSG_W-1:0] in_msg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [KEY_W-1:0] out_chunk,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last
);

  if ((MSG_W % KEY_W) != 0 || MSG_W < KEY_W) begin : g_bad_size
    $error("otp_chunk_streamer: MSG_W must be a non-zero multiple of KEY_W");
  end

  chunk_state_t     state_q, state_d;
  logic [MSG_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic load, advance, finish;

  // The head slice is where the next chunk to leave sits; shifting moves data toward it
  if (MSB_FIRST != 0) begin : g_msb
    assign out_chunk = shift_q[MSG_W-1 -: KEY_W];
  end else begin : g_lsb
    assign out_chunk = shift_q[KEY_W-1:0];
  end

  assign out_valid = (state_q == STREAM);
  assign out_idx   = idx_q;
  assign out_last  = (idx_q == IDX_W'(N - 1));

  // Accepting on the last beat lets a new message follow with no idle cycle
  assign in_ready  = !rst && ((state_q == IDLE) || (out_valid && out_ready && out_last));

  assign load      = in_valid && in_ready;
  assign advance   = out_valid && out_ready && !out_last;
  assign finish    = out_valid && out_ready && out_last;

  // Next-state: a load wins over everything, otherwise step or retire the message
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    if (load) begin
      state_d = STREAM;
      shift_d = in_msg;
      idx_d   = '0;
    end else if (advance) begin
      shift_d = (MSB_FIRST != 0) ? (shift_q << KEY_W) : (shift_q >> KEY_W);
      idx_d   = idx_q + IDX_W'(1);
    end else if (finish) begin
      state_d = IDLE;
    end
  end

  // State, shift register and index registers; reset discards any message in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_otp_chunk_streamer.sv
// tb/tb_otp_chunk_streamer.sv - scoreboard bench for otp_chunk_streamer
module tb_otp_chunk_streamer;

  typedef struct packed {
    logic [15:0] c;
    logic [7:0]  i;
    logic        l;
  } exp_t;

  logic clk, rst;

  logic         iv0, ir0, ov0, or0, ol0;
  logic [239:0] msg0;
  logic [15:0]  oc0;
  logic [3:0]   oi0;

  logic         iv1, ir1, ov1, or1, ol1;
  logic [239:0] msg1;
  logic [15:0]  oc1;
  logic [3:0]   oi1;

  logic         iv2, ir2, ov2, or2, ol2;
  logic [15:0]  msg2;
  logic [15:0]  oc2;
  logic [0:0]   oi2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_vec = 0;
  int n_err = 0;

  otp_chunk_streamer u_msb (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_msg(msg0),
    .out_valid(ov0), .out_ready(or0), .out_chunk(oc0), .out_idx(oi0), .out_last(ol0)
  );

  otp_chunk_streamer #(.MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_msg(msg1),
    .out_valid(ov1), .out_ready(or1), .out_chunk(oc1), .out_idx(oi1), .out_last(ol1)
  );

  otp_chunk_streamer #(.MSG_W(16), .KEY_W(16)) u_n1 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_msg(msg2),
    .out_valid(ov2), .out_ready(or2), .out_chunk(oc2), .out_idx(oi2), .out_last(ol2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [239:0] mk_msg(input logic [15:0] base);
    logic [239:0] m;
    m = '0;
    for (int k = 0; k < 15; k++) m[239 - 16*k -: 16] = base + 16'(k);
    return m;
  endfunction

  // Compare a presented beat against the scoreboard head; pop only on a real transfer
  task automatic mon(input string tag, input logic v, input logic r, input logic [15:0] c,
                     input logic [7:0] i, input logic l, input int sz, input exp_t e,
                     output bit pop);
    pop = 1'b0;
    if (v) begin
      if (sz == 0) begin
        chk({tag, "_unexpected_beat"}, 32'(c), 32'hDEAD_BEEF);
      end else begin
        chk({tag, "_chunk"}, 32'(c), 32'(e.c));
        chk({tag, "_idx"},   32'(i), 32'(e.i));
        chk({tag, "_last"},  32'(l), 32'(e.l));
        pop = r;
      end
    end
  endtask

  always @(negedge clk) begin
    bit p;
    if (!rst) begin
      mon("msb", ov0, or0, oc0, 8'(oi0), ol0, q0.size(), (q0.size() != 0) ? q0[0] : '0, p);
      if (p) void'(q0.pop_front());
      mon("lsb", ov1, or1, oc1, 8'(oi1), ol1, q1.size(), (q1.size() != 0) ? q1[0] : '0, p);
      if (p) void'(q1.pop_front());
      mon("n1", ov2, or2, oc2, 8'(oi2), ol2, q2.size(), (q2.size() != 0) ? q2[0] : '0, p);
      if (p) void'(q2.pop_front());
    end
  end

  // Called at posedge+1; leaves in_valid high and returns at posedge+1 after the accepting edge
  task automatic load0(input logic [15:0] base, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    iv0  = 1'b1;
    msg0 = mk_msg(base);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ir0) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    chk("msb_load_accepted", 32'(ok), 32'd1);
    for (int k = 0; k < 15; k++) q0.push_back('{c: base + 16'(k), i: 8'(k), l: (k == 14)});
    @(posedge clk);
    #1;
  endtask

  task automatic drain0();
    for (int t = 0; t < 300 && q0.size() != 0; t++) @(posedge clk);
    #1;
    chk("msb_drained", 32'(q0.size()), 32'd0);
  endtask

  initial begin
    int w;
    bit ok;
    rst = 1'b1;
    iv0 = 1'b0; msg0 = '0; or0 = 1'b1;
    iv1 = 1'b0; msg1 = '0; or1 = 1'b1;
    iv2 = 1'b0; msg2 = '0; or2 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready_low", 32'(ir0), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(ov0), 32'd0);
    chk("rst_out_idx",   32'(oi0), 32'd0);
    chk("rst_out_chunk", 32'(oc0), 32'd0);
    chk("rst_out_last",  32'(ol0), 32'd0);
    chk("rst_in_ready",  32'(ir0), 32'd1);

    // Basic stream, full throughput
    @(posedge clk); #1;
    load0(16'h0001, w);
    iv0 = 1'b0;
    chk("basic_idle_wait", 32'(w), 32'd0);
    chk("basic_first_valid", 32'(ov0), 32'd1);
    drain0();
    @(negedge clk);
    chk("basic_valid_after_last", 32'(ov0), 32'd0);

    // Backpressure: out_ready 1,0,0,1,0,0,...
    @(posedge clk); #1;
    load0(16'h0001, w);
    iv0 = 1'b0;
    for (int c = 0; c < 300 && q0.size() != 0; c++) begin
      or0 = (c % 3 == 0);
      @(posedge clk); #1;
    end
    or0 = 1'b1;
    chk("bp_all_transferred", 32'(q0.size()), 32'd0);

    // Back-to-back A then B with in_valid held
    @(posedge clk); #1;
    load0(16'hA000, w);
    load0(16'hB000, w);
    chk("b2b_in_ready_only_on_last", 32'(w), 32'd14);
    iv0 = 1'b0;
    @(negedge clk);
    chk("b2b_no_bubble_valid", 32'(ov0), 32'd1);
    chk("b2b_no_bubble_idx", 32'(oi0), 32'd0);
    drain0();

    // Load attempt while busy is ignored
    @(posedge clk); #1;
    load0(16'hA000, w);
    iv0 = 1'b0;
    for (int k = 0; k < 5; k++) begin @(posedge clk); #1; end
    chk("busy_at_chunk5", 32'(oi0), 32'd5);
    iv0  = 1'b1;
    msg0 = '1;
    @(negedge clk);
    chk("busy_in_ready", 32'(ir0), 32'd0);
    @(posedge clk); #1;
    iv0 = 1'b0;
    drain0();

    // Reset during chunk 7
    @(posedge clk); #1;
    load0(16'hC000, w);
    iv0 = 1'b0;
    for (int k = 0; k < 7; k++) begin @(posedge clk); #1; end
    chk("rst_mid_at_chunk7", 32'(oi0), 32'd7);
    rst = 1'b1;
    q0.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(ov0), 32'd0);
    chk("rst_mid_idx",   32'(oi0), 32'd0);
    chk("rst_mid_ready", 32'(ir0), 32'd1);
    chk("rst_mid_chunk", 32'(oc0), 32'd0);
    @(posedge clk); #1;
    load0(16'hD000, w);
    iv0 = 1'b0;
    drain0();

    // LSB-first order on the same message
    @(posedge clk); #1;
    iv1  = 1'b1;
    msg1 = mk_msg(16'h0001);
    ok   = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ir1) begin ok = 1'b1; break; end
    end
    chk("lsb_load_accepted", 32'(ok), 32'd1);
    for (int j = 0; j < 15; j++) q1.push_back('{c: 16'h000F - 16'(j), i: 8'(j), l: (j == 14)});
    @(posedge clk); #1;
    iv1 = 1'b0;
    for (int t = 0; t < 100 && q1.size() != 0; t++) @(posedge clk);
    #1;
    chk("lsb_drained", 32'(q1.size()), 32'd0);

    // Single-chunk messages, one per cycle
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) begin
      msg2 = 16'h5A00 + 16'(j);
      iv2  = 1'b1;
      @(negedge clk);
      chk("n1_in_ready", 32'(ir2), 32'd1);
      if (j > 0) chk("n1_back_to_back_valid", 32'(ov2), 32'd1);
      q2.push_back('{c: 16'h5A00 + 16'(j), i: 8'd0, l: 1'b1});
      @(posedge clk); #1;
    end
    iv2 = 1'b0;
    for (int t = 0; t < 20 && q2.size() != 0; t++) @(posedge clk);
    #1;
    chk("n1_drained", 32'(q2.size()), 32'd0);
    @(negedge clk);
    chk("n1_idle_after", 32'(ov2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
